// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: format codes,
// RISC-V major opcodes and the immediate expansion function.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'b000,
    FMT_S    = 3'b001,
    FMT_U    = 3'b010,
    FMT_B    = 3'b101,
    FMT_J    = 3'b110,
    FMT_NONE = 3'b111
  } imm_fmt_e;

  // Reported on imm_fmt when auto decode finds no legal format.
  localparam logic [2:0] FMT_AUTO_ILLEGAL = 3'b011;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_W     = 7'b0111011;

  // Upper 32 bits are a sign extension only for 64-bit datapaths.
  function automatic logic [63:0] imm_expand(input logic [31:0] instr,
                                             input imm_fmt_e    fmt,
                                             input logic        xlen64);
    logic [31:0] imm32;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return xlen64 ? {{32{imm32[31]}}, imm32} : {32'b0, imm32};
  endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational opcode-to-format decode with legality; the word-sized
// opcodes are only legal on a 64-bit datapath.
module imm_fmt_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0] opcode_i,
  output logic [2:0] fmt_o,
  output logic       legal_o
);

  always_comb begin
    fmt_o   = FMT_AUTO_ILLEGAL;
    legal_o = 1'b0;
    case (opcode_i)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt_o   = FMT_I;
        legal_o = 1'b1;
      end
      OPC_OP_IMM_W: begin
        if (XLEN == 64) begin
          fmt_o   = FMT_I;
          legal_o = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt_o   = FMT_S;
        legal_o = 1'b1;
      end
      OPC_BRANCH: begin
        fmt_o   = FMT_B;
        legal_o = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o   = FMT_U;
        legal_o = 1'b1;
      end
      OPC_JAL: begin
        fmt_o   = FMT_J;
        legal_o = 1'b1;
      end
      OPC_OP: begin
        fmt_o   = FMT_NONE;
        legal_o = 1'b1;
      end
      OPC_OP_W: begin
        if (XLEN == 64) begin
          fmt_o   = FMT_NONE;
          legal_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage at the decode/execute boundary.
// Handshake: an entry moves on in_valid && in_ready; in_ready = !out_valid || out_ready.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [2:0]       imm_fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  logic [2:0]      dec_fmt;
  logic            dec_legal;
  logic            man_legal;
  logic [2:0]      fmt_sel;
  logic            fmt_legal;
  logic [63:0]     imm_full;
  logic            accept;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [2:0]       fmt_q, fmt_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  if (AUTO_DECODE != 0) begin : g_auto
    imm_fmt_decode #(.XLEN(XLEN)) u_decode (
      .opcode_i (instr[6:0]),
      .fmt_o    (dec_fmt),
      .legal_o  (dec_legal)
    );
  end else begin : g_manual
    assign dec_fmt   = FMT_AUTO_ILLEGAL;
    assign dec_legal = 1'b0;
  end

  assign man_legal = (imm_src != 3'b011) && (imm_src != 3'b100);
  assign fmt_sel   = (AUTO_DECODE != 0) ? dec_fmt : imm_src;
  assign fmt_legal = (AUTO_DECODE != 0) ? dec_legal : man_legal;
  assign imm_full  = fmt_legal ? imm_expand(instr, imm_fmt_e'(fmt_sel), XLEN == 64)
                               : 64'b0;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    imm_d     = imm_q;
    fmt_d     = fmt_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (accept) begin
      valid_d   = 1'b1;
      imm_d     = imm_full[XLEN-1:0];
      fmt_d     = fmt_sel;
      illegal_d = !fmt_legal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // A flush discards both the held entry and one accepted this cycle.
    if (flush) valid_d = 1'b0;
    if (accept && !flush && !fmt_legal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      imm_q     <= '0;
      fmt_q     <= 3'b000;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign imm_ext       = imm_q;
  assign imm_fmt       = fmt_q;
  assign illegal       = illegal_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: four builds (XLEN=32, XLEN=64, 8-bit
// counter, manual format select) share one stimulus stream.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic [15:0] a_cnt;

  logic        w_in_ready, w_out_valid, w_illegal;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;
  logic [15:0] w_cnt;

  logic        c_in_ready, c_out_valid, c_illegal;
  logic [31:0] c_imm;
  logic [2:0]  c_fmt;
  logic [7:0]  c_cnt;

  logic        m_in_ready, m_out_valid, m_illegal;
  logic [31:0] m_imm;
  logic [2:0]  m_fmt;
  logic [15:0] m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm_ext(a_imm), .imm_fmt(a_fmt), .illegal(a_illegal), .illegal_count(a_cnt));

  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1), .CNT_W(16)) u_w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(w_out_valid), .out_ready(out_ready),
    .imm_ext(w_imm), .imm_fmt(w_fmt), .illegal(w_illegal), .illegal_count(w_cnt));

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(c_out_valid), .out_ready(out_ready),
    .imm_ext(c_imm), .imm_fmt(c_fmt), .illegal(c_illegal), .illegal_count(c_cnt));

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(0), .CNT_W(16)) u_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(m_out_valid), .out_ready(out_ready),
    .imm_ext(m_imm), .imm_fmt(m_fmt), .illegal(m_illegal), .illegal_count(m_cnt));

  // addi -1, sw -4, beq +16, lui, jal -8, addiw -1, add
  localparam logic [31:0] VEC_INSTR [7] = '{32'hFFF00093, 32'hFE112E23, 32'h00000863,
                                             32'h123452B7, 32'hFF9FF06F, 32'hFFF0009B,
                                             32'h002081B3};
  localparam logic [31:0] EXP32 [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000010,
                                        32'h12345000, 32'hFFFFFFF8, 32'h0, 32'h0};
  localparam logic [2:0]  FMT32 [7] = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110,
                                        3'b011, 3'b111};
  localparam logic        ILL32 [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [63:0] EXP64 [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                        64'h10, 64'h12345000, 64'hFFFFFFFFFFFFFFF8,
                                        64'hFFFFFFFFFFFFFFFF, 64'h0};
  localparam logic [2:0]  FMT64 [7] = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110,
                                        3'b000, 3'b111};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; imm_src = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_imm_ext",   64'(a_imm),       64'd0);
    check("rst_imm_fmt",   64'(a_fmt),       64'd0);
    check("rst_illegal",   64'(a_illegal),   64'd0);
    check("rst_count",     64'(a_cnt),       64'd0);
    check("rst_in_ready",  64'(a_in_ready),  64'd1);
    rst = 1'b0;

    // Back-to-back accepts, one per cycle.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      instr    = VEC_INSTR[i];
      @(negedge clk);
      check($sformatf("v%0d_valid32", i), 64'(a_out_valid), 64'd1);
      check($sformatf("v%0d_imm32", i),   64'(a_imm),       64'(EXP32[i]));
      check($sformatf("v%0d_fmt32", i),   64'(a_fmt),       64'(FMT32[i]));
      check($sformatf("v%0d_ill32", i),   64'(a_illegal),   64'(ILL32[i]));
      check($sformatf("v%0d_imm64", i),   w_imm,            EXP64[i]);
      check($sformatf("v%0d_fmt64", i),   64'(w_fmt),       64'(FMT64[i]));
      check($sformatf("v%0d_ill64", i),   64'(w_illegal),   64'd0);
    end
    check("cnt32_addiw", 64'(a_cnt), 64'd1);
    check("cnt64_addiw", 64'(w_cnt), 64'd0);

    // Illegal opcode, then a long run to saturate the 8-bit counter.
    instr = 32'h0000007F;
    @(negedge clk);
    check("ill_flag", 64'(a_illegal), 64'd1);
    check("ill_imm",  64'(a_imm),     64'd0);
    check("ill_fmt",  64'(a_fmt),     64'd3);
    check("ill_cnt",  64'(a_cnt),     64'd2);
    repeat (299) @(negedge clk);
    in_valid = 1'b0;
    check("sat_cnt16", 64'(a_cnt), 64'd301);
    check("sat_cnt8",  64'(c_cnt), 64'd255);
    @(negedge clk);
    check("drain_valid", 64'(a_out_valid), 64'd0);

    // Stall for five cycles, then release with a new entry waiting.
    in_valid = 1'b1;
    instr    = VEC_INSTR[0];
    @(negedge clk);
    out_ready = 1'b0;
    instr     = VEC_INSTR[3];
    #1;
    check("stall_in_ready0", 64'(a_in_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), 64'(a_out_valid), 64'd1);
      check($sformatf("stall%0d_imm", k),   64'(a_imm),       64'hFFFFFFFF);
      check($sformatf("stall%0d_ready", k), 64'(a_in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    check("release_imm",   64'(a_imm),       64'h12345000);
    check("release_fmt",   64'(a_fmt),       64'd2);
    check("release_valid", 64'(a_out_valid), 64'd1);

    // Flush together with an accepted illegal entry.
    instr = 32'h0000007F;
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(a_out_valid), 64'd0);
    check("flush_cnt16", 64'(a_cnt),       64'd301);
    check("flush_cnt8",  64'(c_cnt),       64'd255);

    // Reset while stalled on an illegal entry.
    in_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_illegal", 64'(a_illegal), 64'd1);
    check("pre_rst_cnt",     64'(a_cnt),     64'd302);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_stall", 64'(a_out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid",    64'(a_out_valid), 64'd0);
    check("midrst_imm",      64'(a_imm),       64'd0);
    check("midrst_fmt",      64'(a_fmt),       64'd0);
    check("midrst_illegal",  64'(a_illegal),   64'd0);
    check("midrst_cnt",      64'(a_cnt),       64'd0);
    check("midrst_in_ready", 64'(a_in_ready),  64'd1);
    rst       = 1'b0;
    out_ready = 1'b1;

    // Manual format select.
    in_valid = 1'b1;
    imm_src  = 3'b100;
    instr    = 32'h00000013;
    @(negedge clk);
    check("man_illegal", 64'(m_illegal), 64'd1);
    check("man_fmt",     64'(m_fmt),     64'd4);
    check("man_imm",     64'(m_imm),     64'd0);
    check("man_cnt",     64'(m_cnt),     64'd1);
    imm_src = 3'b001;
    instr   = 32'hFE112E23;
    @(negedge clk);
    check("man_s_imm",     64'(m_imm),     64'hFFFFFFFC);
    check("man_s_fmt",     64'(m_fmt),     64'd1);
    check("man_s_illegal", 64'(m_illegal), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the pipelined RISC-V core. It sits at the decode/execute boundary and takes a full 32-bit instruction word. It either decodes the immediate format from the opcode or takes it from an external `imm_src`, then produces a sign-extended XLEN-wide immediate. The result moves through a one-entry valid/ready pipeline register with stall, flush and illegal-format reporting.

## Interface
- `XLEN`, default 32: output width; legal values are 32 and 64.
- `AUTO_DECODE`, default 1: 1 derives the format from `instr[6:0]`; 0 uses the `imm_src` port.
- `CNT_W`, default 16: width of the saturating illegal-format counter.

- `clk`  in  1: clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `flush`  in  1: kill the held entry and any entry accepted this cycle.
- `in_valid`  in  1: `instr` and `imm_src` are valid.
- `in_ready`  out  1: the stage can accept this cycle.
- `instr`  in  32: instruction word.
- `imm_src`  in  3: format select; ignored when `AUTO_DECODE`=1.
- `out_valid`  out  1: the registered result is valid.
- `out_ready`  in  1: downstream consumes the result.
- `imm_ext`  out  XLEN: sign-extended immediate.
- `imm_fmt`  out  3: format used.
- `illegal`  out  1: the held entry had no legal format.
- `illegal_count`  out  CNT_W: count of accepted illegal entries, saturating.

## Operation
- Format codes: 000 I, 001 S, 101 B, 010 U, 110 J, 111 NONE (R-type; immediate 0, legal). 011 and 100 are illegal.
- Auto decode by opcode:
  - 0010011, 0000011 and 1100111 map to I.
  - 0011011 maps to I only when XLEN=64; otherwise it is illegal.
  - 0100011 maps to S; 1100011 maps to B.
  - 0110111 and 0010111 map to U; 1101111 maps to J.
  - 0110011 maps to NONE; 0111011 maps to NONE only when XLEN=64.
  - Every other opcode is illegal.
- Immediates, all sign-extended from `instr[31]` to XLEN:
  - I = `instr[31:20]`.
  - S = `{instr[31:25], instr[11:7]}`.
  - B = `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U = `{instr[31:12], 12'b0}`.
  - J = `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- An illegal entry produces `imm_ext`=0, `illegal`=1 and `imm_fmt` equal to the raw code (auto mode reports 011). The entry still occupies the stage and handshakes normally.
- `illegal_count` increments on every accepted, non-flushed illegal entry and saturates at all-ones.

## Timing
- Reset values: `out_valid`=0, `imm_ext`=0, `imm_fmt`=000, `illegal`=0, `illegal_count`=0. Reset takes priority over every other input.
- `in_ready` = `!out_valid || out_ready`. It is combinational, with no dependence on `in_valid`.
- Accept happens when `in_valid && in_ready`. The result appears on the outputs the next cycle: 1-cycle latency.
- Back-to-back throughput is one entry per cycle while `out_ready`=1.
- Stall: when `out_valid && !out_ready`, all outputs hold stable and `in_ready`=0.
- Flush: `out_valid`=0 next cycle, and an entry accepted in the same cycle is discarded and not counted. The data registers may keep stale values.
- Flush and reset mid-stall behave the same way: the held entry is lost.
- Once `out_valid` is high, it falls only through consumption with no new accept, a flush, or a reset.

## Structure
- Shared package `imm_pkg` holds:
  - the `imm_fmt_e` enum (I, S, B, U, J, NONE);
  - the opcode constants;
  - a pure function `imm_expand(instr, fmt, xlen64)`.
- One sub-module, `imm_fmt_decode`, contains the combinational opcode-to-format and legality logic. It is instantiated only when `AUTO_DECODE`=1.
- The top level holds the pipeline register, the handshake and the counter.

## Test plan
- Auto decode, XLEN=32, accept one entry per cycle with `out_ready`=1:
  - `0xFFF00093` (addi -1) gives `imm_ext`=`0xFFFFFFFF`, fmt 000.
  - `0xFE112E23` (sw -4) gives `0xFFFFFFFC`, fmt 001.
  - `0x00000863` (beq +16) gives `0x00000010`, fmt 101.
  - `0x123452B7` (lui) gives `0x12345000`, fmt 010.
  - `0xFF9FF06F` (jal -8) gives `0xFFFFFFF8`, fmt 110.
- XLEN=64, `0xFF9FF06F` gives `0xFFFFFFFFFFFFFFF8`. Opcode 0011011 (addiw) is legal here but is illegal with XLEN=32.
- Illegal opcode `0x0000007F`:
  - `illegal`=1 and `imm_ext`=0;
  - the counter increments;
  - in an 8-bit CNT_W build it saturates at 255 after 300 entries.
- Stall: hold `out_ready`=0 for 5 cycles after an accept. `in_ready`=0 and the outputs stay stable. Releasing `out_ready` lets the next entry be accepted on that same cycle.
- Assert `flush` and `in_valid` together with an illegal instruction. The next cycle shows `out_valid`=0 and the counter is unchanged.
- Apply `rst` mid-stall. The next cycle shows every output at its reset value and `in_ready`=1.
- Manual mode (`AUTO_DECODE`=0) with `imm_src`=100 gives `illegal`=1 and `imm_fmt`=100.
